// File: rtl/mult_seq.sv
// Sequential 32x32 -> 64 radix-2 shift-add multiplier, signed (MULT) or unsigned (MULTU).
// One multiply at a time; fixed latency regardless of operand values.
//
// state | meaning
// IDLE  | waiting for start; operands sampled here only
// CALC  | 32 shift-add steps (cnt 0..31), then one sign-fixup cycle that loads hi/lo
// DONE  | hi/lo valid, done pulse; returns to IDLE unconditionally
module mult_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        fixup;
  logic        neg;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;

  // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  assign a_mag = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (is_signed && b[31]) ? (~b + 32'd1) : b;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      fixup  <= 1'b0;
      neg    <= 1'b0;
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplier <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
            neg    <= is_signed & (a[31] ^ b[31]);
            acc    <= 64'd0;
            cnt    <= 5'd0;
            fixup  <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (!fixup) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) fixup <= 1'b1;
          end else begin
            // Negation gets its own cycle so it never chains onto the last add.
            {hi, lo} <= neg ? (~acc + 64'd1) : acc;
            fixup    <= 1'b0;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: the driver pushes expected products, a negedge monitor
// pops and checks them when done pulses, along with latency, pulse width and hold.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;
  exp_t q[$];

  logic        prev_done = 1'b0;
  logic [63:0] last_out = 64'd0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_out = 64'd0;
    end else if (done) begin
      if (prev_done) begin
        tests++; fails++;
        $display("FAIL done_width: done high two cycles running at cycle %0d", cyc);
      end
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got %h_%h at cycle %0d, nothing expected", hi, lo, cyc);
      end else begin
        e = q.pop_front();
        tests++;
        if ({hi, lo} !== e.prod) begin
          fails++;
          $display("FAIL product: got %h_%h expected %h", hi, lo, e.prod);
        end
        tests++;
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL latency: done at cycle %0d expected %0d", cyc, e.cyc);
        end
      end
      last_out = {hi, lo};
    end else begin
      tests++;
      if ({hi, lo} !== last_out) begin
        fails++;
        $display("FAIL hold: hi/lo %h_%h changed without done, expected %h", hi, lo, last_out);
      end
    end
    prev_done = done;
  end

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  // Call just after a negedge with the DUT in IDLE; returns just after the accept edge.
  task automatic issue(input logic s, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [63:0] prod);
    exp_t e;
    is_signed = s; a = ai; b = bi; start = 1'b1;
    e.prod = prod;
    e.cyc  = cyc + 34;
    q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done, optionally scrambling the operand inputs meanwhile; ends just after
  // the negedge of the first IDLE cycle.
  task automatic run_to_done(input bit scramble);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (scramble) begin
        a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within 40 cycles (busy=%0b)", busy);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[$] = '{
    '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001},
    '{1'b1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF},
    '{1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF},
    '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000},
    '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000},
    '{1'b0, 32'h00000000, 32'h12345678, 64'h00000000_00000000},
    '{1'b1, 32'h12345678, 32'h00000000, 64'h00000000_00000000},
    '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1},
    '{1'b0, 32'h00000003, 32'h00000005, 64'h00000000_0000000F},
    '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2},
    '{1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000}
  };

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic [31:0] x;
    logic [31:0] y;

    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%0b done=%0b hi=%h lo=%h, all zero expected", busy, done, hi, lo);
    end

    // Start on the very edge that first sees rst_n released.
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      issue(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].p);
      run_to_done(1'b0);
    end

    // Starts at CALC cycle 5 and in the DONE cycle are ignored; the next cycle accepts.
    issue(1'b0, 32'h00000002, 32'h00000003, 64'd6);
    begin
      int n;
      bit seen;
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        if (done) begin
          seen = 1'b1;
          is_signed = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        end else if (n == 5) begin
          is_signed = 1'b1; a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      if (!seen) begin
        tests++; fails++;
        $display("FAIL done_timeout: ignored-start scenario, no done");
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL start_in_done: busy=%0b after DONE, expected 0", busy);
      end
    end
    issue(1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000);
    run_to_done(1'b1);

    // Reset mid-CALC aborts with no done; hi/lo clear immediately.
    issue(1'b0, 32'hDEADBEEF, 32'h00000002, 64'h00000001_BD5B7DDE);
    repeat (16) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL abort_flags: busy=%0b done=%0b, expected 0 0", busy, done);
    end
    tests++;
    if ({hi, lo} !== 64'd0) begin
      fails++;
      $display("FAIL abort_outputs: hi=%h lo=%h, expected zero", hi, lo);
    end
    void'(q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h00001234, 32'h00000010, 64'h00000000_00012340);
    run_to_done(1'b1);

    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      issue(s, x, y, ref_mul(s, x, y));
      run_to_done(1'b1);
    end

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_done: %0d results never produced, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
